// File: rtl/bitonic_sort_ctrl_if.sv
// Handshake and frame buses between the bitonic sort controller and its neighbours.
// The controller connects through the slave modport; the stream source/sink and sorter use master.
// Widths follow the controller's WIDTH/DEPTH so the flat frame buses line up.
interface bitonic_sort_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   sort_valid_in;
  logic [WIDTH*DEPTH-1:0] sort_seq_in;
  logic                   sort_valid_out;
  logic [WIDTH*DEPTH-1:0] sort_seq_out;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   busy;
  logic                   err;

  modport master (
    output in_valid, in_data, in_last, sort_valid_out, sort_seq_out, out_ready,
    input  in_ready, sort_valid_in, sort_seq_in, out_valid, out_data, out_last, busy, err
  );

  modport slave (
    input  in_valid, in_data, in_last, sort_valid_out, sort_seq_out, out_ready,
    output in_ready, sort_valid_in, sort_seq_in, out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/bitonic_sort_ctrl.sv
// Stream-to-frame controller for a pipelined bitonic sorter: fills a DEPTH-word frame
// (padded so short frames sort pads to the tail), launches it, captures the result and
// drains the real words in order. Optional macro BITONIC_CTRL_TIMEOUT_EN adds a sorter timeout.
module bitonic_sort_ctrl #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 32,
  parameter int DIR      = 1,
  parameter int SORT_LAT = 12,
  parameter int TO_SLACK = 4
) (
  input logic clk,
  input logic rst,
  bitonic_sort_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] PAD = (DIR != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  localparam logic [0:0] I_FILL  = 1'b0;
  localparam logic [0:0] I_PEND  = 1'b1;
  localparam logic [1:0] O_IDLE  = 2'd0;
  localparam logic [1:0] O_WAIT  = 2'd1;
  localparam logic [1:0] O_DRAIN = 2'd2;

`ifdef BITONIC_CTRL_TIMEOUT_EN
  localparam int TO_MAX = SORT_LAT + TO_SLACK;
  localparam int TW = $clog2(TO_MAX + 1);
  logic [TW-1:0] tmo;
`endif

  logic [0:0]       istate;
  logic [1:0]       ostate;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    rd;
  logic [CW-1:0]    n_out;
  logic [WIDTH-1:0] fbuf [DEPTH];
  logic [WIDTH-1:0] obuf [DEPTH];
  logic             err_q;
  logic             rdy_en;
  logic             launch;
  logic             accept;
  logic             last_word;
  logic [WIDTH*DEPTH-1:0] seq_flat;

  // Launch happens when a complete frame waits and the output side is free.
  assign launch    = (istate == I_PEND) && (ostate == O_IDLE);
  assign accept    = rdy_en && (istate == I_FILL) && bus.in_valid;
  assign last_word = (rd == n_out - CW'(1));

  assign bus.in_ready      = rdy_en && (istate == I_FILL);
  assign bus.sort_valid_in = launch;
  assign bus.sort_seq_in   = seq_flat;
  assign bus.out_valid     = (ostate == O_DRAIN);
  assign bus.out_data      = (ostate == O_DRAIN) ? obuf[rd[IW-1:0]] : '0;
  assign bus.out_last      = (ostate == O_DRAIN) && last_word;
  assign bus.busy          = (ostate != O_IDLE) || launch;
  assign bus.err           = err_q;

  // Frame bus is only driven during the launch pulse; pad slots already hold PAD.
  always_comb begin
    seq_flat = '0;
    if (launch) begin
      for (int i = 0; i < DEPTH; i++) seq_flat[i*WIDTH +: WIDTH] = fbuf[i];
    end
  end

  // Keeps in_ready low while reset is applied and releases it one cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Input FSM: accept words into the fill buffer, hold the frame until launch, then re-pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      istate <= I_FILL;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) fbuf[i] <= PAD;
    end else if (launch) begin
      istate <= I_FILL;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) fbuf[i] <= PAD;
    end else if (accept) begin
      fbuf[cnt[IW-1:0]] <= bus.in_data;
      cnt               <= cnt + CW'(1);
      if (bus.in_last || (cnt == CW'(DEPTH - 1))) istate <= I_PEND;
    end
  end

  // Output FSM: wait for the sorter result, capture it, drain only the real words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ostate <= O_IDLE;
      rd     <= '0;
      n_out  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) obuf[i] <= '0;
`ifdef BITONIC_CTRL_TIMEOUT_EN
      tmo    <= '0;
`endif
    end else begin
      case (ostate)
        O_IDLE: begin
          if (bus.sort_valid_out) err_q <= 1'b1;
          if (launch) begin
            ostate <= O_WAIT;
            n_out  <= cnt;
            rd     <= '0;
`ifdef BITONIC_CTRL_TIMEOUT_EN
            tmo    <= '0;
`endif
          end
        end
        O_WAIT: begin
          if (bus.sort_valid_out) begin
            for (int i = 0; i < DEPTH; i++) obuf[i] <= bus.sort_seq_out[i*WIDTH +: WIDTH];
            rd     <= '0;
            ostate <= O_DRAIN;
          end
`ifdef BITONIC_CTRL_TIMEOUT_EN
          // Sorter never answered: flag it and drop the frame without output.
          else if (tmo == TW'(TO_MAX - 1)) begin
            err_q  <= 1'b1;
            ostate <= O_IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
`endif
        end
        O_DRAIN: begin
          if (bus.sort_valid_out) err_q <= 1'b1;
          if (bus.out_ready) begin
            if (last_word) begin
              ostate <= O_IDLE;
              rd     <= '0;
            end else begin
              rd <= rd + CW'(1);
            end
          end
        end
        default: ostate <= O_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl (DEPTH=4, WIDTH=8, DIR=1, SORT_LAT=12) with a
// behavioural ascending sorter; expected streams are hand-written constants.
// Test 6 is compiled only when BITONIC_CTRL_TIMEOUT_EN is defined.
module tb_bitonic_sort_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int SORT_LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   launches = 0;
  int   launch_cyc = 0;
  int   cd = 0;
  logic sv = 1'b0;
  logic spur = 1'b0;
  logic sorter_en = 1'b1;
  logic [31:0] last_bus = '0;
  logic [31:0] sorted = '0;
  logic [7:0]  exp_w [4];

  bitonic_sort_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  bitonic_sort_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DIR(1), .SORT_LAT(SORT_LAT), .TO_SLACK(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.sort_valid_out = sv | spur;
  assign bus.sort_seq_out   = sorted;

  function automatic logic [31:0] sort_asc(input logic [31:0] v);
    logic [7:0]  a [4];
    logic [7:0]  t;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  // Behavioural sorter: captures each launch and answers SORT_LAT-ish cycles later.
  always @(negedge clk) begin
    if (rst) begin
      cd <= 0;
      sv <= 1'b0;
    end else begin
      sv <= 1'b0;
      if (bus.sort_valid_in) begin
        launches   <= launches + 1;
        launch_cyc <= cyc;
        last_bus   <= bus.sort_seq_in;
        sorted     <= sort_asc(bus.sort_seq_in);
        cd         <= sorter_en ? SORT_LAT - 1 : 0;
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) sv <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [31:0] words, input int n, input bit last_flag);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = words[i*8 +: 8];
      bus.in_last  = last_flag && (i == n - 1);
      while (!bus.in_ready && b < 100) begin @(negedge clk); b++; end
      if (!bus.in_ready) chk("send_timeout", 64'd0, 64'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv(input int n, input int nframe, input bit toggle, output int last_hs);
    int   got;
    int   budget;
    bit   rdy;
    bit   stalled;
    logic [7:0] held;
    got = 0; budget = 0; rdy = 1'b1; stalled = 1'b0; held = '0; last_hs = 0;
    while (got < n && budget < 300) begin
      @(negedge clk);
      budget++;
      if (stalled) begin
        chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stall_data", {56'd0, bus.out_data}, {56'd0, held});
        stalled = 1'b0;
      end
      bus.out_ready = toggle ? rdy : 1'b1;
      rdy = !rdy;
      if (bus.out_valid && bus.out_ready) begin
        chk("out_data", {56'd0, bus.out_data}, {56'd0, exp_w[got]});
        chk("out_last", {63'd0, bus.out_last}, {63'd0, (got == nframe - 1)});
        got++;
        last_hs = cyc;
      end else if (bus.out_valid) begin
        held    = bus.out_data;
        stalled = 1'b1;
      end
    end
    if (got < n) chk("recv_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    int hs;
    int base;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", {56'd0, bus.out_data}, 64'd0);
    chk("rst_out_last", {63'd0, bus.out_last}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_sort_valid_in", {63'd0, bus.sort_valid_in}, 64'd0);
    chk("rst_sort_seq_in", {32'd0, bus.sort_seq_in}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_err", {63'd0, bus.err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    // 1: full frame 7,3,9,1
    base = launches;
    send_frame(32'h01_09_03_07, 4, 1'b0);
    exp_w = '{8'd1, 8'd3, 8'd7, 8'd9};
    recv(4, 4, 1'b0, hs);
    @(negedge clk);
    chk("t1_launch_count", 64'(launches - base), 64'd1);
    chk("t1_bus", {32'd0, last_bus}, 64'h01_09_03_07);
    chk("t1_err", {63'd0, bus.err}, 64'd0);
    chk("t1_idle_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t1_idle_busy", {63'd0, bus.busy}, 64'd0);

    // 2: short frame 5,2(last)
    send_frame(32'h00_00_02_05, 2, 1'b1);
    exp_w = '{8'd2, 8'd5, 8'hFF, 8'hFF};
    recv(2, 2, 1'b0, hs);
    chk("t2_bus", {32'd0, last_bus}, 64'hFF_FF_02_05);
    repeat (3) begin
      @(negedge clk);
      chk("t2_no_pad_out", {63'd0, bus.out_valid}, 64'd0);
    end

    // 3: back-to-back frames, stalling drain, next frame fills during drain
    send_frame(32'h1E_14_28_0A, 4, 1'b0);
    exp_w = '{8'd10, 8'd20, 8'd30, 8'd40};
    fork
      send_frame(32'h60_80_05_C0, 4, 1'b0);
      recv(4, 4, 1'b1, hs);
    join
    exp_w = '{8'h05, 8'h60, 8'h80, 8'hC0};
    recv(4, 4, 1'b1, base);
    chk("t3_launch_after_hs", 64'(launch_cyc), 64'(hs + 1));
    chk("t3_bus", {32'd0, last_bus}, 64'h60_80_05_C0);
    chk("t3_err", {63'd0, bus.err}, 64'd0);

    // 4: spurious sorter pulse while idle
    repeat (2) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("t4_err_set", {63'd0, bus.err}, 64'd1);
    chk("t4_no_out", {63'd0, bus.out_valid}, 64'd0);
    send_frame(32'h08_00_04_04, 4, 1'b0);
    exp_w = '{8'd0, 8'd4, 8'd4, 8'd8};
    recv(4, 4, 1'b0, hs);
    chk("t4_err_sticky", {63'd0, bus.err}, 64'd1);

    // 5: reset mid-drain after two words, then a frame with in_last on the final slot
    send_frame(32'h44_11_33_22, 4, 1'b0);
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    recv(2, 4, 1'b0, hs);
    @(negedge clk);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t5_out_data", {56'd0, bus.out_data}, 64'd0);
    chk("t5_out_last", {63'd0, bus.out_last}, 64'd0);
    chk("t5_busy", {63'd0, bus.busy}, 64'd0);
    chk("t5_err_clr", {63'd0, bus.err}, 64'd0);
    chk("t5_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(32'h04_02_08_06, 4, 1'b1);
    exp_w = '{8'd2, 8'd4, 8'd6, 8'd8};
    recv(4, 4, 1'b0, hs);
    chk("t5_bus", {32'd0, last_bus}, 64'h04_02_08_06);
    chk("t5_err", {63'd0, bus.err}, 64'd0);

`ifdef BITONIC_CTRL_TIMEOUT_EN
    // 6: sorter never answers
    begin
      int b;
      int lc;
      sorter_en = 1'b0;
      send_frame(32'h04_03_02_01, 4, 1'b0);
      b = 0;
      while (!bus.sort_valid_in && b < 50) begin @(negedge clk); b++; end
      chk("t6_launch_seen", {63'd0, bus.sort_valid_in}, 64'd1);
      lc = cyc;
      while (cyc < lc + 16) begin
        @(negedge clk);
        chk("t6_no_out", {63'd0, bus.out_valid}, 64'd0);
      end
      chk("t6_err_early", {63'd0, bus.err}, 64'd0);
      @(negedge clk);
      chk("t6_err_set", {63'd0, bus.err}, 64'd1);
      chk("t6_idle", {63'd0, bus.busy}, 64'd0);
      sorter_en = 1'b1;
      send_frame(32'h07_05_06_08, 4, 1'b0);
      exp_w = '{8'd5, 8'd6, 8'd7, 8'd8};
      recv(4, 4, 1'b0, hs);
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
